// File: rtl/seq_code_validator.sv
// Serial code-word validator: assembles WIDTH bits MSB-first, classifies each
// completed word against a truth table, and keeps saturating good/bad tallies.
module seq_code_validator #(
   parameter int                        WIDTH       = 6,
   parameter logic [(1 << WIDTH) - 1:0] VALID_TABLE = 64'hFFFF_0000_AAAA_5555,
   parameter int                        CNT_W       = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             bit_in,
   input  logic             bit_valid,
   input  logic             abort,
   input  logic             clear_counts,
   output logic             busy,
   output logic             word_done,
   output logic             word_ok,
   output logic [WIDTH-1:0] word_value,
   output logic [CNT_W-1:0] ok_count,
   output logic [CNT_W-1:0] bad_count
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [CW-1:0]    bit_count;
   logic [CW-1:0]    count_next;
   logic [WIDTH-1:0] shift_reg;
   logic [WIDTH-1:0] full_word;
   logic             accept;
   logic             complete;
   logic             verdict;

   // Next-state and bit-count logic; abort wins over any bit arriving that cycle.
   always_comb begin
      state_next = state;
      count_next = bit_count;
      complete   = 1'b0;
      accept     = bit_valid & ~abort;
      full_word  = {shift_reg[WIDTH-2:0], bit_in};
      verdict    = VALID_TABLE[full_word];
      if (abort) begin
         state_next = IDLE;
         count_next = '0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (bit_valid) begin
                  state_next = SHIFT;
                  count_next = CW'(1);
               end else begin
                  state_next = IDLE;
                  count_next = '0;
               end
            end
            SHIFT: begin
               if (bit_valid) begin
                  if (bit_count == CW'(WIDTH - 1)) begin
                     complete   = 1'b1;
                     state_next = DONE;
                     count_next = '0;
                  end else begin
                     count_next = bit_count + CW'(1);
                  end
               end
            end
            default: begin
               state_next = IDLE;
               count_next = '0;
            end
         endcase
      end
   end

   // Status outputs decoded straight from the state register.
   always_comb begin
      busy      = (state == SHIFT);
      word_done = (state == DONE);
   end

   // State, shifter, captured word/verdict and saturating tallies.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         bit_count  <= '0;
         shift_reg  <= '0;
         word_value <= '0;
         word_ok    <= 1'b0;
         ok_count   <= '0;
         bad_count  <= '0;
      end else begin
         state     <= state_next;
         bit_count <= count_next;
         if (accept) begin
            shift_reg <= full_word;
         end
         if (complete) begin
            word_value <= full_word;
            word_ok    <= verdict;
         end
         if (clear_counts) begin
            ok_count  <= '0;
            bad_count <= '0;
         end else if (complete) begin
            if (verdict) begin
               if (ok_count != {CNT_W{1'b1}}) begin
                  ok_count <= ok_count + CNT_W'(1);
               end
            end else begin
               if (bad_count != {CNT_W{1'b1}}) begin
                  bad_count <= bad_count + CNT_W'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_seq_code_validator.sv
// Scoreboard bench for seq_code_validator: directed scenarios plus random
// traffic, checked against a bit-queue reference model.
module tb_seq_code_validator;

   localparam int          WIDTH = 6;
   localparam int          CNT_W = 2;
   localparam logic [63:0] TABLE = 64'hFFFF_0000_AAAA_5555;
   localparam int          CMAX  = (1 << CNT_W) - 1;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             bit_in = 1'b0;
   logic             bit_valid = 1'b0;
   logic             abort = 1'b0;
   logic             clear_counts = 1'b0;
   logic             busy;
   logic             word_done;
   logic             word_ok;
   logic [WIDTH-1:0] word_value;
   logic [CNT_W-1:0] ok_count;
   logic [CNT_W-1:0] bad_count;

   typedef struct {
      int value;
      int ok;
      int okc;
      int badc;
   } exp_t;

   exp_t sb[$];
   int   bits[$];
   int   m_ok = 0, m_bad = 0, m_value = 0, m_okv = 0;
   int   exp_done = 0, exp_busy = 0;
   int   check_count = 0, error_count = 0;
   bit   mon_en = 1'b0;

   seq_code_validator #(
      .WIDTH(WIDTH),
      .VALID_TABLE(TABLE),
      .CNT_W(CNT_W)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bit_in(bit_in),
      .bit_valid(bit_valid),
      .abort(abort),
      .clear_counts(clear_counts),
      .busy(busy),
      .word_done(word_done),
      .word_ok(word_ok),
      .word_value(word_value),
      .ok_count(ok_count),
      .bad_count(bad_count)
   );

   // Free-running clock, 10 time-unit period.
   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input int actual, input int expected);
      check_count++;
      if (actual !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Drive one cycle of inputs, then advance the reference model across the edge.
   task automatic applyStimulus(input bit v, input bit b, input bit ab, input bit clr, input bit rst);
      int  w;
      bit  done;
      bit_valid    = v;
      bit_in       = b;
      abort        = ab;
      clear_counts = clr;
      reset        = rst;
      @(posedge clock);
      done     = 1'b0;
      exp_done = 0;
      w        = 0;
      if (rst) begin
         bits.delete();
         m_ok = 0; m_bad = 0; m_value = 0; m_okv = 0;
      end else begin
         if (ab) begin
            bits.delete();
         end else if (v) begin
            bits.push_back(int'(b));
            if (bits.size() == WIDTH) begin
               foreach (bits[i]) w = w * 2 + bits[i];
               bits.delete();
               done = 1'b1;
            end
         end
         if (done) begin
            m_value = w;
            m_okv   = int'(TABLE[w]);
         end
         if (clr) begin
            m_ok = 0; m_bad = 0;
         end else if (done) begin
            if (m_okv == 1) m_ok  = (m_ok  < CMAX) ? m_ok  + 1 : CMAX;
            else            m_bad = (m_bad < CMAX) ? m_bad + 1 : CMAX;
         end
         if (done) begin
            sb.push_back('{value: w, ok: m_okv, okc: m_ok, badc: m_bad});
            exp_done = 1;
         end
      end
      exp_busy = (bits.size() > 0) ? 1 : 0;
      mon_en   = 1'b1;
      #1;
   endtask

   task automatic sendWord(input int w, input int gap_after, input int gap_len);
      for (int i = WIDTH - 1; i >= 0; i--) begin
         applyStimulus(1'b1, w[i], 1'b0, 1'b0, 1'b0);
         if ((WIDTH - i) == gap_after) begin
            for (int g = 0; g < gap_len; g++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Monitor: samples mid-cycle, checks held state every cycle, pops on word_done.
   always @(negedge clock) begin
      exp_t e;
      if (mon_en) begin
         checkOutput("busy", int'(busy), exp_busy);
         checkOutput("word_done", int'(word_done), exp_done);
         checkOutput("word_value", int'(word_value), m_value);
         checkOutput("word_ok", int'(word_ok), m_okv);
         checkOutput("ok_count", int'(ok_count), m_ok);
         checkOutput("bad_count", int'(bad_count), m_bad);
         if (word_done === 1'b1) begin
            if (sb.size() == 0) begin
               checkOutput("sb_unexpected_done", 1, 0);
            end else begin
               e = sb.pop_front();
               checkOutput("sb_value", int'(word_value), e.value);
               checkOutput("sb_ok", int'(word_ok), e.ok);
               checkOutput("sb_okc", int'(ok_count), e.okc);
               checkOutput("sb_badc", int'(bad_count), e.badc);
            end
         end
      end
   end

   // Directed scenarios followed by randomized traffic.
   initial begin
      int r;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("reset_value", int'(word_value), 0);
      checkOutput("reset_busy", int'(busy), 0);

      sendWord(6'h00, 0, 0);
      idle(2);
      sendWord(6'h01, 0, 0);
      sendWord(6'h3F, 0, 0);
      idle(2);
      sendWord(6'h11, 3, 3);
      idle(1);
      for (int i = 5; i >= 2; i--) applyStimulus(1'b1, r[0], 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      sendWord(6'h10, 0, 0);
      idle(1);
      for (int k = 0; k < 5; k++) sendWord(6'h20, 0, 0);
      for (int i = WIDTH - 1; i >= 1; i--) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      sendWord(6'h2A, 0, 0);
      idle(1);
      sendWord(6'h3F, 0, 0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(1);

      for (int n = 0; n < 3000; n++) begin
         r = $urandom;
         applyStimulus(r[1:0] != 2'b00, r[2], r[9:5] == 5'd0, r[15:10] == 6'd0, r[23:16] == 8'd0);
      end
      idle(3);
      checkOutput("sb_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", check_count, error_count);
      $finish;
   end

endmodule

// File: doc/seq_code_validator.md
Name: seq_code_validator

Overview:
- Serial, parametrised successor to the team's combinational 6-input "valid" decoder.
- Bits arrive one per clock through a valid-qualified input and are assembled MSB-first into a WIDTH-bit word.
- Each completed word is classified against a parameter truth table. The block reports the word, a one-cycle done pulse and the verdict.
- Keeps saturating good/bad word counts for the lab display logic downstream.

Parameters:
- WIDTH, 6, word length in bits (2..8).
- VALID_TABLE, 64'hFFFF_0000_AAAA_5555, truth table of 2**WIDTH bits; word w is valid iff VALID_TABLE[w] == 1.
- CNT_W, 8, width of ok_count and bad_count.

Ports:
- clock  input  1  single system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- bit_in  input  1  serial data bit, MSB of the word first.
- bit_valid  input  1  bit_in is accepted on any clock edge where bit_valid=1 (no backpressure).
- abort  input  1  discards the partially assembled word.
- clear_counts  input  1  zeroes both counters.
- busy  output  1  1 while a partial word (1..WIDTH-1 bits) is held.
- word_done  output  1  one-cycle pulse: a word completed.
- word_ok  output  1  verdict for the current word_value; meaningful when word_done=1, held afterward.
- word_value  output  WIDTH  last completed word; held until the next completion.
- ok_count  output  CNT_W  number of valid words, saturating.
- bad_count  output  CNT_W  number of invalid words, saturating.

Behaviour:
- Reset (synchronous, active-high): all outputs are 0, shift register is 0, bit counter is 0, state is IDLE. Reset overrides every other input in the same cycle.
- States:
  - IDLE: no bits held.
  - SHIFT: 1..WIDTH-1 bits held.
  - DONE: one cycle; word_done=1.
- IDLE/DONE + bit_valid -> SHIFT, bit count = 1. The exception is WIDTH reached, which cannot happen from IDLE since WIDTH >= 2.
- IDLE/DONE + no bit_valid -> IDLE.
- SHIFT + bit_valid: shift_reg <= {shift_reg[WIDTH-2:0], bit_in} and the count increments.
  - When the count reaches WIDTH: word_value <= completed word, word_ok <= VALID_TABLE[completed word], and the next state is DONE.
- SHIFT + no bit_valid: hold (gaps between bits are allowed, with no timeout).
- Latency: if the WIDTH-th bit is accepted at edge k, word_done is high in the cycle after edge k (exactly one cycle).
- A bit accepted during the DONE cycle is the first bit of the next word. Back-to-back words with zero gap are supported; word_done then pulses every WIDTH cycles.
- abort=1 (not reset): count <= 0, state <= IDLE, and any bit_valid in that cycle is ignored.
  - word_value and word_ok are not changed.
  - Abort during DONE does not cancel the pulse already visible, and the counters still count that word.
- Counters: on the edge that completes a word, ok_count or bad_count increments by 1 and saturates at 2**CNT_W-1.
- clear_counts has priority over a same-edge increment: both counters go to 0 and that word is not counted.
- busy = (state == SHIFT).
- Shift register upper bits beyond the current count are don't-care. Only the full word is ever exposed.

Test Plan:
- Reset, then shift 0,0,0,0,0,0 on consecutive cycles -> word_done pulses one cycle after the 6th bit; word_value=6'h00, word_ok=1, ok_count=1, bad_count=0.
- Back-to-back words 6'h01 then 6'h3F with no gap -> two word_done pulses 6 cycles apart. Verdicts are word_ok=0 then 1; final ok_count=2, bad_count=1 (running totals).
- Shift 6'h11 with bit_valid deasserted for 3 cycles after bit 3 -> busy stays 1 through the gap; word_value=6'h11, word_ok=1.
- Shift 4 bits of 6'h10, assert abort, then shift 6'h10 fully -> a single word_done, word_value=6'h10, word_ok=0, bad_count+1. The aborted bits do not corrupt the word.
- CNT_W=2: send 5 words of 6'h20 -> bad_count saturates at 3. Then clear_counts on the same edge as a 6th completion -> both counts 0.
- Assert reset after 3 bits of a word -> all outputs 0 next cycle. The following 6 bits form a fresh word.
